// File: rtl/tx_fc_credit_gate.sv
// ---------------------------------------------------------------------------
// tx_fc_credit_gate
//
// Transmit-side flow-control credit gate. Each cycle it looks at two
// candidate TLP descriptors from the Tx arbiter and grants at most one. A
// grant is given only when the modulo credit-gating rule passes for both the
// header and the data counters of the candidate's type (P, NP or CPL).
// Credit limits come from InitFC / UpdateFC values delivered by the DLL.
// Credits consumed advance on every grant.
//
// Optional feature macro: TX_FC_BLOCK_CNT_EN
//   When defined, adds o_fc_block_cnt, a saturating count of FC_ACTIVE cycles
//   in which a candidate was valid but nothing was granted.
//
// Ports:
//   clk, rst            core clock, synchronous active-high reset
//   i_dl_up             data link up; low forces FC_IDLE and clears all state
//   i_fc_init_*         InitFC beat (type 01 P, 10 NP, 11 CPL; 0 = infinite)
//   i_fc_update_*       UpdateFC beat (new credit limits, same type encoding)
//   i_ptlp_1/2          candidate payload length in DW (0 = 1024)
//   i_command_1/2       {has_data, type[1:0]}; type 00 = no request
//   o_result            00 FAIL, 01 SUCCESS1, 10 SUCCESS2 (combinational)
//   o_fc_ready          high while in FC_ACTIVE (registered)
//   o_fc_block_cnt      blocked-cycle counter (TX_FC_BLOCK_CNT_EN only)
// ---------------------------------------------------------------------------
module tx_fc_credit_gate #(
    parameter int unsigned FC_HDR_WIDTH  = 12,
    parameter int unsigned FC_DATA_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_dl_up,
    input  logic                     i_fc_init_valid,
    input  logic [1:0]               i_fc_init_type,
    input  logic [FC_HDR_WIDTH-1:0]  i_fc_init_hdr,
    input  logic [FC_DATA_WIDTH-1:0] i_fc_init_data,
    input  logic                     i_fc_update_valid,
    input  logic [1:0]               i_fc_update_type,
    input  logic [FC_HDR_WIDTH-1:0]  i_fc_update_hdr,
    input  logic [FC_DATA_WIDTH-1:0] i_fc_update_data,
    input  logic [9:0]               i_ptlp_1,
    input  logic [9:0]               i_ptlp_2,
    input  logic [2:0]               i_command_1,
    input  logic [2:0]               i_command_2,
`ifdef TX_FC_BLOCK_CNT_EN
    output logic [15:0]              o_fc_block_cnt,
`endif
    output logic [1:0]               o_result,
    output logic                     o_fc_ready
);

    localparam int unsigned NUM_TYPES = 3;

    localparam logic [FC_HDR_WIDTH-1:0]  HDR_ONE   = {{(FC_HDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [FC_HDR_WIDTH-1:0]  HDR_HALF  = {1'b1, {(FC_HDR_WIDTH-1){1'b0}}};
    localparam logic [FC_DATA_WIDTH-1:0] DATA_HALF = {1'b1, {(FC_DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        FC_IDLE   = 2'b00,
        FC_INIT   = 2'b01,
        FC_ACTIVE = 2'b10
    } fc_state_e;

    fc_state_e state_q;
    logic      fc_ready_q;

    // Per-type credit state; index 0 = P, 1 = NP, 2 = CPL (type code - 1).
    logic [FC_HDR_WIDTH-1:0]  hdr_cl_q  [NUM_TYPES];
    logic [FC_HDR_WIDTH-1:0]  hdr_cl_d  [NUM_TYPES];
    logic [FC_HDR_WIDTH-1:0]  hdr_cc_q  [NUM_TYPES];
    logic [FC_HDR_WIDTH-1:0]  hdr_cc_d  [NUM_TYPES];
    logic [FC_DATA_WIDTH-1:0] data_cl_q [NUM_TYPES];
    logic [FC_DATA_WIDTH-1:0] data_cl_d [NUM_TYPES];
    logic [FC_DATA_WIDTH-1:0] data_cc_q [NUM_TYPES];
    logic [FC_DATA_WIDTH-1:0] data_cc_d [NUM_TYPES];
    logic [NUM_TYPES-1:0]     hdr_inf_q,  hdr_inf_d;
    logic [NUM_TYPES-1:0]     data_inf_q, data_inf_d;
    logic [NUM_TYPES-1:0]     seen_q,     seen_d;

    logic                     active;
    logic                     valid_1, valid_2;
    logic                     pass_1,  pass_2;
    logic                     grant_1, grant_2, grant_any;
    logic [FC_DATA_WIDTH-1:0] dreq_1,  dreq_2, g_dreq;
    logic [1:0]               g_type;

    // Data credits for a payload: ceil(len/4), len 0 meaning 1024 DW.
    function automatic logic [FC_DATA_WIDTH-1:0] data_req(input logic       has_data,
                                                          input logic [9:0] len);
        logic [10:0] dw;
        logic [10:0] credits;
        dw      = (len == 10'd0) ? 11'd1024 : {1'b0, len};
        credits = (dw + 11'd3) >> 2;
        return has_data ? FC_DATA_WIDTH'(credits) : '0;
    endfunction

    // Modulo gate: the limit must be no more than half the counter range
    // ahead of the consumed count after this request.
    function automatic logic hdr_ok(input logic                    inf,
                                    input logic [FC_HDR_WIDTH-1:0] cl,
                                    input logic [FC_HDR_WIDTH-1:0] cc);
        logic [FC_HDR_WIDTH-1:0] diff;
        diff = cl - (cc + HDR_ONE);
        return inf || (diff <= HDR_HALF);
    endfunction

    function automatic logic data_ok(input logic                     inf,
                                     input logic [FC_DATA_WIDTH-1:0] cl,
                                     input logic [FC_DATA_WIDTH-1:0] cc,
                                     input logic [FC_DATA_WIDTH-1:0] req);
        logic [FC_DATA_WIDTH-1:0] diff;
        diff = cl - (cc + req);
        return inf || (diff <= DATA_HALF);
    endfunction

    // -----------------------------------------------------------------------
    // Gate decision (combinational on registered credit state)
    // -----------------------------------------------------------------------
    assign active  = (state_q == FC_ACTIVE);
    assign valid_1 = (i_command_1[1:0] != 2'b00);
    assign valid_2 = (i_command_2[1:0] != 2'b00);
    assign dreq_1  = data_req(i_command_1[2], i_ptlp_1);
    assign dreq_2  = data_req(i_command_2[2], i_ptlp_2);

    always_comb begin
        pass_1 = 1'b0;
        pass_2 = 1'b0;
        for (int unsigned t = 0; t < NUM_TYPES; t++) begin
            if (i_command_1[1:0] == 2'(t + 1)) begin
                pass_1 = hdr_ok(hdr_inf_q[t], hdr_cl_q[t], hdr_cc_q[t]) &&
                         data_ok(data_inf_q[t], data_cl_q[t], data_cc_q[t], dreq_1);
            end
            if (i_command_2[1:0] == 2'(t + 1)) begin
                pass_2 = hdr_ok(hdr_inf_q[t], hdr_cl_q[t], hdr_cc_q[t]) &&
                         data_ok(data_inf_q[t], data_cl_q[t], data_cc_q[t], dreq_2);
            end
        end
    end

    assign grant_1   = active & valid_1 & pass_1;
    assign grant_2   = active & ~grant_1 & valid_2 & pass_2;
    assign grant_any = grant_1 | grant_2;
    assign g_type    = grant_1 ? i_command_1[1:0] : i_command_2[1:0];
    assign g_dreq    = grant_1 ? dreq_1 : dreq_2;

    assign o_result   = {grant_2, grant_1};
    assign o_fc_ready = fc_ready_q;

    // -----------------------------------------------------------------------
    // Credit state next-value
    // -----------------------------------------------------------------------
    always_comb begin
        hdr_cl_d   = hdr_cl_q;
        hdr_cc_d   = hdr_cc_q;
        data_cl_d  = data_cl_q;
        data_cc_d  = data_cc_q;
        hdr_inf_d  = hdr_inf_q;
        data_inf_d = data_inf_q;
        seen_d     = seen_q;

        if (!i_dl_up) begin
            hdr_cl_d   = '{default: '0};
            hdr_cc_d   = '{default: '0};
            data_cl_d  = '{default: '0};
            data_cc_d  = '{default: '0};
            hdr_inf_d  = '0;
            data_inf_d = '0;
            seen_d     = '0;
        end else if (state_q == FC_INIT) begin
            for (int unsigned t = 0; t < NUM_TYPES; t++) begin
                if (i_fc_init_valid && (i_fc_init_type == 2'(t + 1))) begin
                    hdr_cl_d[t]   = i_fc_init_hdr;
                    data_cl_d[t]  = i_fc_init_data;
                    hdr_inf_d[t]  = (i_fc_init_hdr == '0);
                    data_inf_d[t] = (i_fc_init_data == '0);
                    hdr_cc_d[t]   = '0;
                    data_cc_d[t]  = '0;
                    seen_d[t]     = 1'b1;
                end
            end
        end else if (active) begin
            // Grant and UpdateFC may hit the same type in one cycle; the
            // decision above already used the pre-update limit.
            for (int unsigned t = 0; t < NUM_TYPES; t++) begin
                if (grant_any && (g_type == 2'(t + 1))) begin
                    if (!hdr_inf_q[t]) begin
                        hdr_cc_d[t] = hdr_cc_q[t] + HDR_ONE;
                    end
                    if (!data_inf_q[t]) begin
                        data_cc_d[t] = data_cc_q[t] + g_dreq;
                    end
                end
                if (i_fc_update_valid && (i_fc_update_type == 2'(t + 1))) begin
                    if (!hdr_inf_q[t]) begin
                        hdr_cl_d[t] = i_fc_update_hdr;
                    end
                    if (!data_inf_q[t]) begin
                        data_cl_d[t] = i_fc_update_data;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_cl_q   <= '{default: '0};
            hdr_cc_q   <= '{default: '0};
            data_cl_q  <= '{default: '0};
            data_cc_q  <= '{default: '0};
            hdr_inf_q  <= '0;
            data_inf_q <= '0;
            seen_q     <= '0;
        end else begin
            hdr_cl_q   <= hdr_cl_d;
            hdr_cc_q   <= hdr_cc_d;
            data_cl_q  <= data_cl_d;
            data_cc_q  <= data_cc_d;
            hdr_inf_q  <= hdr_inf_d;
            data_inf_q <= data_inf_d;
            seen_q     <= seen_d;
        end
    end

    // -----------------------------------------------------------------------
    // Link state machine
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FC_IDLE;
            fc_ready_q <= 1'b0;
        end else if (!i_dl_up) begin
            state_q    <= FC_IDLE;
            fc_ready_q <= 1'b0;
        end else begin
            case (state_q)
                FC_IDLE: begin
                    state_q    <= FC_INIT;
                    fc_ready_q <= 1'b0;
                end
                FC_INIT: begin
                    // Uses seen_d so the beat completing the set moves us to
                    // FC_ACTIVE on the same edge it is loaded.
                    if (&seen_d) begin
                        state_q    <= FC_ACTIVE;
                        fc_ready_q <= 1'b1;
                    end
                end
                FC_ACTIVE: begin
                    fc_ready_q <= 1'b1;
                end
                default: begin
                    state_q    <= FC_IDLE;
                    fc_ready_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef TX_FC_BLOCK_CNT_EN
    logic [15:0] blk_cnt_q, blk_cnt_d;

    always_comb begin
        blk_cnt_d = blk_cnt_q;
        if (!i_dl_up) begin
            blk_cnt_d = '0;
        end else if (active && (valid_1 || valid_2) && !grant_any && (blk_cnt_q != '1)) begin
            blk_cnt_d = blk_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blk_cnt_q <= '0;
        end else begin
            blk_cnt_q <= blk_cnt_d;
        end
    end

    assign o_fc_block_cnt = blk_cnt_q;
`endif

endmodule
